// File: rtl/sweep_sched_pkg.sv
// Shared encodings for the sweep scheduler: mode values, DDS ramp register
// addresses, FSM states and the latched command frame.
package sweep_sched_pkg;

   localparam logic [1:0] MODE_STOP  = 2'd0;
   localparam logic [1:0] MODE_BAND1 = 2'd1;
   localparam logic [1:0] MODE_BAND2 = 2'd2;
   localparam logic [1:0] MODE_ALT   = 2'd3;

   localparam logic [1:0] ADDR_LOWER = 2'd0;
   localparam logic [1:0] ADDR_UPPER = 2'd1;
   localparam logic [1:0] ADDR_STEP  = 2'd2;
   localparam logic [1:0] ADDR_RATE  = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_CFG,
      S_WR_LO,
      S_WR_HI,
      S_WR_STEP,
      S_WR_RATE,
      S_IOUPD,
      S_SWEEP,
      S_DROP
   } state_e;

   // Decoded command frame as held in the shadow registers.
   typedef struct packed {
      logic [31:0] lo1;
      logic [31:0] hi1;
      logic [31:0] lo2;
      logic [31:0] hi2;
      logic [31:0] step;
      logic [15:0] rate;
      logic [31:0] period;
      logic [1:0]  mode;
      logic        rf_switch;
   } frame_t;

   // A programmed period of zero ticks is treated as one tick.
   function automatic logic [31:0] period_eff(input logic [31:0] p);
      return (p == 32'd0) ? 32'd1 : p;
   endfunction

endpackage

// File: rtl/sweep_timer.sv
// Sweep window timer: a prescaler producing one tick every PRESCALE cycles and
// a period counter of ticks. start marks the first cycle of the window; done
// is high in the last cycle, max(period,1)*PRESCALE cycles after start.
module sweep_timer
   import sweep_sched_pkg::*;
#(
   parameter int unsigned PRESCALE = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] period,
   output logic        done
);

   logic [15:0] pre_q;
   logic [31:0] per_q;
   logic        run_q;
   logic        active;
   logic        pre_wrap;

   // Counters rest at zero while idle, so the start cycle is already count 0.
   assign active   = start | run_q;
   assign pre_wrap = (pre_q == 16'(PRESCALE - 1));
   assign done     = active & pre_wrap & (per_q == (period_eff(period) - 32'd1));

   // Advance prescaler and tick counter while the window is open.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pre_q <= '0;
         per_q <= '0;
         run_q <= 1'b0;
      end else if (done) begin
         pre_q <= '0;
         per_q <= '0;
         run_q <= 1'b0;
      end else if (active) begin
         run_q <= 1'b1;
         if (pre_wrap) begin
            pre_q <= '0;
            per_q <= per_q + 32'd1;
         end else begin
            pre_q <= pre_q + 16'd1;
         end
      end
   end

endmodule

// File: rtl/sweep_sched.sv
// Sweep scheduler: accepts a decoded frame from the depacketiser, programs the
// DDS ramp registers word by word, then runs timed sweeps with DRCTL, swapping
// bands at every sweep boundary in alternate mode.
module sweep_sched
   import sweep_sched_pkg::*;
#(
   parameter int unsigned PRESCALE = 100,
   parameter int unsigned DROP_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   output logic        load,
   input  logic [31:0] ftw_lower_1,
   input  logic [31:0] ftw_upper_1,
   input  logic [31:0] ftw_lower_2,
   input  logic [31:0] ftw_upper_2,
   input  logic [31:0] sweep_step,
   input  logic [15:0] sweep_rate,
   input  logic [31:0] resweep_period,
   input  logic [1:0]  mode,
   input  logic        rf_switch,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [1:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        io_update,
   output logic        drctl,
   output logic        rf_en,
   output logic        band,
   output logic        busy
);

   state_e      state_q;
   frame_t      frame_q;
   frame_t      frame_in;
   logic        load_q;
   logic        wr_valid_q;
   logic [1:0]  wr_addr_q;
   logic [31:0] wr_data_q;
   logic        io_update_q;
   logic        drctl_q;
   logic        rf_en_q;
   logic        band_q;
   logic        start_q;
   logic [7:0]  drop_q;
   logic        timer_done;

   assign frame_in = '{lo1: ftw_lower_1, hi1: ftw_upper_1, lo2: ftw_lower_2,
                       hi2: ftw_upper_2, step: sweep_step, rate: sweep_rate,
                       period: resweep_period, mode: mode, rf_switch: rf_switch};

   assign load      = load_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign io_update = io_update_q;
   assign drctl     = drctl_q;
   assign rf_en     = rf_en_q;
   assign band      = band_q;
   assign busy      = (state_q != S_IDLE);

   sweep_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (start_q),
      .period (frame_q.period),
      .done   (timer_done)
   );

   // Control FSM: handshake, register programming and sweep scheduling.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         frame_q     <= '0;
         load_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         io_update_q <= 1'b0;
         drctl_q     <= 1'b0;
         rf_en_q     <= 1'b0;
         band_q      <= 1'b0;
         start_q     <= 1'b0;
         drop_q      <= '0;
      end else begin
         load_q      <= 1'b0;
         io_update_q <= 1'b0;
         start_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (ready) begin
                  frame_q <= frame_in;
                  load_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: state_q <= S_CFG;
            S_CFG: begin
               rf_en_q <= frame_q.rf_switch & (frame_q.mode != MODE_STOP);
               band_q  <= (frame_q.mode == MODE_BAND2);
               if (frame_q.mode == MODE_STOP) begin
                  drctl_q <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_WR_LO;
               end
            end
            // Each write state first presents its word, then waits for accept;
            // entering the next state with valid low gives the one-cycle gap.
            S_WR_LO: begin
               if (!wr_valid_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ADDR_LOWER;
                  wr_data_q  <= band_q ? frame_q.lo2 : frame_q.lo1;
               end else if (wr_ready) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= S_WR_HI;
               end
            end
            S_WR_HI: begin
               if (!wr_valid_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ADDR_UPPER;
                  wr_data_q  <= band_q ? frame_q.hi2 : frame_q.hi1;
               end else if (wr_ready) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= S_WR_STEP;
               end
            end
            S_WR_STEP: begin
               if (!wr_valid_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ADDR_STEP;
                  wr_data_q  <= frame_q.step;
               end else if (wr_ready) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= S_WR_RATE;
               end
            end
            S_WR_RATE: begin
               if (!wr_valid_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ADDR_RATE;
                  wr_data_q  <= {16'h0000, frame_q.rate};
               end else if (wr_ready) begin
                  wr_valid_q  <= 1'b0;
                  io_update_q <= 1'b1;
                  state_q     <= S_IOUPD;
               end
            end
            S_IOUPD: begin
               drctl_q <= 1'b1;
               start_q <= 1'b1;
               state_q <= S_SWEEP;
            end
            S_SWEEP: begin
               if (timer_done) begin
                  drctl_q <= 1'b0;
                  drop_q  <= '0;
                  state_q <= S_DROP;
               end
            end
            S_DROP: begin
               if (drop_q == 8'(DROP_CYC - 1)) begin
                  if (ready) begin
                     frame_q <= frame_in;
                     load_q  <= 1'b1;
                     state_q <= S_LOAD;
                  end else if (frame_q.mode == MODE_ALT) begin
                     band_q  <= ~band_q;
                     state_q <= S_WR_LO;
                  end else begin
                     drctl_q <= 1'b1;
                     start_q <= 1'b1;
                     state_q <= S_SWEEP;
                  end
               end else begin
                  drop_q <= drop_q + 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_sched.sv
// Randomized bench for sweep_sched: a negedge monitor logs bus events with
// cycle stamps, and each frame is checked against the expected write list,
// io_update placement and sweep/drop lengths derived from the frame fields.
module tb_sweep_sched;

   localparam int PRE   = 4;
   localparam int DROPC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ready = 1'b0;
   logic        load;
   logic [31:0] lo1 = '0, hi1 = '0, lo2 = '0, hi2 = '0, step = '0;
   logic [15:0] rate = '0;
   logic [31:0] per = '0;
   logic [1:0]  mode = '0;
   logic        rfsw = 1'b0;
   logic        wr_valid;
   logic        wr_ready = 1'b1;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic        io_update, drctl, rf_en, band, busy;
   logic [40:0] outs;

   int n_chk = 0, n_pass = 0, cyc = 0, stall_hi = 0, wr_mode = 0, hold_cnt = 0;
   bit sweeping = 0;
   int xa[$], xb[$], xc[$], io_q[$], ld_q[$], rise_q[$], fall_q[$];
   logic [31:0] xd[$];

   assign outs = {load, wr_valid, wr_addr, wr_data, io_update, drctl, rf_en, band, busy};

   always #5 clk = ~clk;

   sweep_sched #(.PRESCALE(PRE), .DROP_CYC(DROPC)) dut (
      .clk(clk), .rst(rst), .ready(ready), .load(load),
      .ftw_lower_1(lo1), .ftw_upper_1(hi1), .ftw_lower_2(lo2), .ftw_upper_2(hi2),
      .sweep_step(step), .sweep_rate(rate), .resweep_period(per),
      .mode(mode), .rf_switch(rfsw),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .io_update(io_update), .drctl(drctl), .rf_en(rf_en), .band(band), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Downstream writer: 0 always ready, 1 random, 2 seven-cycle stall on the upper word, 3 never.
   initial forever begin
      @(posedge clk); #1;
      case (wr_mode)
         0: wr_ready = 1'b1;
         1: wr_ready = ($urandom_range(2, 0) != 0);
         2: begin
            if (wr_valid && wr_addr == 2'd1 && hold_cnt < 7) begin
               wr_ready = 1'b0;
               hold_cnt++;
            end else begin
               wr_ready = 1'b1;
               if (!(wr_valid && wr_addr == 2'd1)) hold_cnt = 0;
            end
         end
         default: wr_ready = 1'b0;
      endcase
   end

   // Event monitor, sampled on the falling edge.
   initial begin
      bit p_stall = 0, p_drctl = 0;
      logic [1:0]  p_addr = '0;
      logic [31:0] p_data = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            p_stall = 0;
            p_drctl = drctl;
         end else begin
            if (p_stall) begin
               check("wr_hold_valid", wr_valid, 1);
               check("wr_hold_addr", wr_addr, p_addr);
               check("wr_hold_data", wr_data, p_data);
               check("drctl_in_wr", drctl, 0);
            end
            if (wr_valid && wr_ready) begin
               xa.push_back(int'(wr_addr));
               xd.push_back(wr_data);
               xb.push_back(int'(band));
               xc.push_back(cyc);
            end
            if (wr_valid && !wr_ready && wr_addr == 2'd1) stall_hi++;
            if (io_update) io_q.push_back(cyc);
            if (load) ld_q.push_back(cyc);
            if (drctl && !p_drctl) rise_q.push_back(cyc);
            if (!drctl && p_drctl) fall_q.push_back(cyc);
            p_stall = wr_valid && !wr_ready;
            p_addr  = wr_addr;
            p_data  = wr_data;
            p_drctl = drctl;
         end
      end
   end

   task automatic run_frame(input logic [1:0] m, input int k,
                            input logic [31:0] a_lo1, input logic [31:0] a_hi1,
                            input logic [31:0] a_lo2, input logic [31:0] a_hi2,
                            input logic [31:0] a_step, input logic [15:0] a_rate,
                            input logic [31:0] a_per, input bit a_rf);
      int nl0, nx0, nio0, nr0, nf0, cset, lcyc, lastf, t, xi, nb, len;
      logic b;
      logic [31:0] exp_data;
      if (sweeping) begin
         t = 0;
         while (drctl !== 1'b1 && t < 3000) begin @(posedge clk); #1; t++; end
         if (drctl !== 1'b1) check("sweep_before_reload", drctl, 1);
         repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      end
      nl0 = ld_q.size(); cset = cyc;
      lo1 = a_lo1; hi1 = a_hi1; lo2 = a_lo2; hi2 = a_hi2; step = a_step;
      rate = a_rate; per = a_per; mode = m; rfsw = a_rf; ready = 1'b1;
      t = 0;
      while (ld_q.size() == nl0 && t < 3000) begin @(posedge clk); #1; t++; end
      ready = 1'b0;
      if (ld_q.size() == nl0) begin
         check("load_timeout", 0, 1);
         return;
      end
      lcyc = ld_q[nl0];
      $display("frame mode=%0d sweeps=%0d period=%0d rf=%0d wr_mode=%0d load@%0d", m, k, a_per, a_rf, wr_mode, lcyc);
      if (sweeping) begin
         lastf = -1000;
         foreach (fall_q[i]) if (fall_q[i] < lcyc) lastf = fall_q[i];
         check("load_after_drop", lcyc - lastf, DROPC);
      end else begin
         check("load_latency", lcyc - cset, 2);
      end
      nx0 = xa.size(); nio0 = io_q.size(); nr0 = rise_q.size(); nf0 = fall_q.size();
      if (m == 2'd0) begin
         repeat (4) begin @(posedge clk); #1; end
         check("stop_rf_en", rf_en, 0);
         check("stop_drctl", drctl, 0);
         check("stop_busy", busy, 0);
         check("stop_no_writes", xa.size() - nx0, 0);
         check("stop_load_count", ld_q.size() - nl0, 1);
         sweeping = 0;
         return;
      end
      t = 0;
      while (fall_q.size() < nf0 + k && t < 5000) begin @(posedge clk); #1; t++; end
      if (fall_q.size() < nf0 + k) begin
         check("sweep_timeout", fall_q.size() - nf0, k);
         sweeping = 0;
         return;
      end
      len = ((a_per == 32'd0) ? 1 : int'(a_per)) * PRE;
      b = (m == 2'd2); xi = nx0; nb = 0;
      for (int s = 0; s < k; s++) begin
         if (s == 0 || m == 2'd3) begin
            for (int w = 0; w < 4; w++) begin
               case (w)
                  0: exp_data = b ? a_lo2 : a_lo1;
                  1: exp_data = b ? a_hi2 : a_hi1;
                  2: exp_data = a_step;
                  default: exp_data = {16'h0000, a_rate};
               endcase
               if (xi < xa.size()) begin
                  check("wr_addr", xa[xi], w);
                  check("wr_data", xd[xi], exp_data);
                  check("wr_band", xb[xi], b);
               end else begin
                  check("wr_missing", xa.size(), xi + 1);
               end
               xi++;
            end
            if (nio0 + nb < io_q.size() && xi <= xc.size()) begin
               check("io_after_writes", io_q[nio0 + nb] > xc[xi - 1], 1);
               check("rise_after_io", rise_q[nr0 + s] - io_q[nio0 + nb], 1);
            end else begin
               check("io_missing", io_q.size() - nio0, nb + 1);
            end
            nb++;
         end
         check("sweep_len", fall_q[nf0 + s] - rise_q[nr0 + s], len);
         if (s > 0 && m != 2'd3) check("drop_len", rise_q[nr0 + s] - fall_q[nf0 + s - 1], DROPC);
         if (m == 2'd3) b = ~b;
      end
      check("wr_count", xa.size() - nx0, nb * 4);
      check("io_count", io_q.size() - nio0, nb);
      check("load_count", ld_q.size() - nl0, 1);
      check("rf_en", rf_en, a_rf);
      if (m != 2'd3) check("band_out", band, m == 2'd2);
      sweeping = 1;
   endtask

   initial begin
      int t, nl, cset, s0;
      // Reset held with a frame pending: everything quiet, then a prompt load.
      lo1 = 32'h1000_0000; hi1 = 32'h2000_0000; step = 32'h100; rate = 16'h0010;
      per = 32'd3; mode = 2'd1; rfsw = 1'b1; ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("rst_outputs", outs, 0);
      end
      nl = ld_q.size(); cset = cyc; rst = 1'b1;
      t = 0;
      while (ld_q.size() == nl && t < 6) begin @(posedge clk); #1; t++; end
      if (ld_q.size() > nl) check("rst_release_load", ld_q[nl] - cset <= 2, 1);
      else check("rst_release_load", 0, 1);
      ready = 1'b0;
      rst = 1'b0; repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1; @(posedge clk); #1;
      sweeping = 0;

      wr_mode = 0;
      run_frame(2'd1, 2, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000,
                32'h0000_0100, 16'h0010, 32'd3, 1'b1);
      wr_mode = 1;
      run_frame(2'd3, 4, $urandom, $urandom, $urandom, $urandom, $urandom,
                16'($urandom), 32'd2, 1'b1);
      run_frame(2'd0, 1, $urandom, $urandom, $urandom, $urandom, $urandom,
                16'($urandom), 32'd1, 1'b1);
      s0 = stall_hi; wr_mode = 2;
      run_frame(2'd1, 1, $urandom, $urandom, $urandom, $urandom, $urandom,
                16'($urandom), 32'd2, 1'b0);
      check("bp_stall_cycles", stall_hi - s0, 7);
      wr_mode = 0;
      run_frame(2'd2, 2, $urandom, $urandom, $urandom, $urandom, $urandom,
                16'($urandom), 32'd0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         wr_mode = $urandom_range(1, 0);
         run_frame(2'($urandom_range(3, 0)), $urandom_range(3, 1), $urandom, $urandom,
                   $urandom, $urandom, $urandom, 16'($urandom),
                   32'($urandom_range(4, 0)), 1'($urandom_range(1, 0)));
      end

      // Reset while stalled mid-write.
      rst = 1'b0; repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1; sweeping = 0;
      wr_mode = 3; mode = 2'd1; ready = 1'b1;
      t = 0;
      while (wr_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      ready = 1'b0;
      check("stall_valid", wr_valid, 1);
      repeat (3) begin @(posedge clk); #1; end
      check("stall_hold_valid", wr_valid, 1);
      check("stall_drctl", drctl, 0);
      rst = 1'b0; @(posedge clk); #1;
      check("rst_mid_write", outs, 0);
      @(posedge clk); #1;
      rst = 1'b1; @(posedge clk); #1;
      check("idle_after_rst", outs, 0);
      wr_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
